regfile_param: RTL and testbench

Parametrised general-purpose register file for the single-cycle/multi-cycle CPU datapath. It generalises the fixed 8x32 file with these additions:
- configurable width and depth;
- optional hardwired zero register;
- optional write-to-read bypass;
- a multi-cycle clear sequencer with a busy flag;
- a board display port that either follows a selected address or auto-scans all registers.

---
 rtl/regfile_param.sv | 137 +++++++++++++
 tb/tb_regfile_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised register file with optional zero register and write bypass,
// a sequential clear engine with busy flag, and a follow/scan display port.
// Ports:
//   clock_in, rst                - clock, async active-low reset
//   readReg1/2 -> readData1/2    - combinational read ports
//   writeReg, writeData, regWrite - write port (dropped while busy)
//   clear_req -> busy            - sequential clear of all entries
//   scan_en, showAddress         - display control
//   display_addr, display        - registered address, array contents
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int SCAN_DIV = 4
) (
  input  logic              clock_in,
  input  logic              rst,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] writeData,
  input  logic              regWrite,
  input  logic              clear_req,
  output logic              busy,
  input  logic              scan_en,
  input  logic [ADDR_W-1:0] showAddress,
  output logic [ADDR_W-1:0] display_addr,
  output logic [DATA_W-1:0] display
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic              busy_q, busy_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [ADDR_W-1:0] disp_q, disp_d;

  logic we;
  logic byp1, byp2;
  logic zero1, zero2;

  // A write is legal only when idle and not aimed at a hardwired zero.
  assign we = regWrite && !busy_q &&
              !((ZERO_REG != 0) && (writeReg == '0));

  assign byp1  = (BYPASS != 0) && we && (writeReg == readReg1);
  assign byp2  = (BYPASS != 0) && we && (writeReg == readReg2);
  assign zero1 = (ZERO_REG != 0) && (readReg1 == '0);
  assign zero2 = (ZERO_REG != 0) && (readReg2 == '0);

  assign readData1 = zero1 ? '0 :
                     byp1  ? writeData : mem_q[readReg1];
  assign readData2 = zero2 ? '0 :
                     byp2  ? writeData : mem_q[readReg2];

  assign busy         = busy_q;
  assign display_addr = disp_q;
  assign display      = mem_q[disp_q];

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d   = CLEAR;
          clr_ptr_d = '0;
        end
      end
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[writeReg] = writeData;
    end
    if (state_q == CLEAR) begin
      mem_d[clr_ptr_q] = '0;
    end
  end

  always_comb begin
    div_cnt_d = div_cnt_q;
    disp_d    = disp_q;
    if (!scan_en) begin
      div_cnt_d = '0;
      disp_d    = showAddress;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d = '0;
      disp_d    = disp_q + 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      mem_q     <= '{default: '0};
      state_q   <= IDLE;
      clr_ptr_q <= '0;
      busy_q    <= 1'b0;
      div_cnt_q <= '0;
      disp_q    <= '0;
    end else begin
      mem_q     <= mem_d;
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
      div_cnt_q <= div_cnt_d;
      disp_q    <= disp_d;
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: reset, zero reg, bypass,
// clear sequencing, display follow/scan and async reset mid-clear.
module tb_regfile_param;

  logic        clock_in = 1'b0;
  logic        rst;
  logic [4:0]  readReg1, readReg2, writeReg, showAddress;
  logic [31:0] writeData;
  logic        regWrite, clear_req, scan_en;
  logic [31:0] readData1, readData2, display;
  logic        busy;
  logic [4:0]  display_addr;

  logic [31:0] nb_rd1, nb_rd2, nb_disp;
  logic        nb_busy;
  logic [4:0]  nb_daddr;

  int n_cmp = 0;
  int n_err = 0;
  int cnt;

  always #5 clock_in = ~clock_in;

  regfile_param dut (
    .clock_in(clock_in), .rst(rst),
    .readReg1(readReg1), .readReg2(readReg2),
    .readData1(readData1), .readData2(readData2),
    .writeReg(writeReg), .writeData(writeData),
    .regWrite(regWrite), .clear_req(clear_req),
    .busy(busy), .scan_en(scan_en),
    .showAddress(showAddress),
    .display_addr(display_addr), .display(display)
  );

  regfile_param #(.BYPASS(0)) dut_nb (
    .clock_in(clock_in), .rst(rst),
    .readReg1(readReg1), .readReg2(readReg2),
    .readData1(nb_rd1), .readData2(nb_rd2),
    .writeReg(writeReg), .writeData(writeData),
    .regWrite(regWrite), .clear_req(clear_req),
    .busy(nb_busy), .scan_en(scan_en),
    .showAddress(showAddress),
    .display_addr(nb_daddr), .display(nb_disp)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_in);
    #2;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    regWrite  = 1'b1;
    writeReg  = a;
    writeData = d;
    tick();
    regWrite  = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    readReg1 = '0; readReg2 = '0; writeReg = '0;
    showAddress = '0; writeData = '0;
    regWrite = 1'b0; clear_req = 1'b0; scan_en = 1'b0;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_disp", display, 32'd0);
    chk("rst_daddr", 32'(display_addr), 32'd0);
    tick();
    rst = 1'b1;
    readReg1 = 5'd5; readReg2 = 5'd31;
    #1;
    chk("post_rst_rd1", readData1, 32'd0);
    chk("post_rst_rd2", readData2, 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // write / read
    wr(5'd5, 32'hDEADBEEF);
    readReg1 = 5'd5;
    #1 chk("wr_r5", readData1, 32'hDEADBEEF);

    // zero register
    wr(5'd0, 32'h12345678);
    readReg1 = 5'd0;
    #1 chk("r0_zero", readData1, 32'd0);
    regWrite = 1'b1; writeReg = 5'd0; writeData = 32'hFFFF_FFFF;
    #1 chk("r0_no_byp", readData1, 32'd0);
    regWrite = 1'b0;

    // bypass vs no bypass
    regWrite = 1'b1; writeReg = 5'd7;
    writeData = 32'hA5A5A5A5; readReg2 = 5'd7;
    #1;
    chk("byp_rd2", readData2, 32'hA5A5A5A5);
    chk("nobyp_old", nb_rd2, 32'd0);
    tick();
    regWrite = 1'b0;
    #1;
    chk("nobyp_new", nb_rd2, 32'hA5A5A5A5);
    readReg1 = 5'd7;
    #1 chk("same_addr", readData1, readData2);

    // display follow mode
    wr(5'd4, 32'h44);
    scan_en = 1'b0; showAddress = 5'd4;
    tick();
    #1;
    chk("follow_addr4", 32'(display_addr), 32'd4);
    chk("follow_disp4", display, 32'h44);
    showAddress = 5'd6;
    #1 chk("follow_lat", 32'(display_addr), 32'd4);
    tick();
    #1 chk("follow_addr6", 32'(display_addr), 32'd6);

    // fill and clear
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i));
    end
    readReg1 = 5'd3;
    #1 chk("fill_r3", readData1, 32'd3);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      regWrite = 1'b0;
      #1;
      if (cnt == 4) chk("clr_r3_before", readData1, 32'd3);
      if (cnt == 5) chk("clr_r3_after", readData1, 32'd0);
      if (cnt == 10) begin
        regWrite = 1'b1; writeReg = 5'd9;
        writeData = 32'h999; readReg2 = 5'd9;
        #1 chk("clr_no_byp", readData2, 32'd9);
      end
      if (cnt == 12) begin
        regWrite = 1'b1; writeReg = 5'd2;
        writeData = 32'h222;
      end
      tick();
    end
    regWrite = 1'b0;
    chk("busy_cycles", 32'(cnt), 32'd32);
    chk("busy_low", 32'(busy), 32'd0);
    readReg1 = 5'd9; readReg2 = 5'd2;
    #1;
    chk("drop_r9", readData1, 32'd0);
    chk("drop_r2", readData2, 32'd0);
    for (int i = 0; i < 32; i++) begin
      readReg1 = 5'(i);
      #1 chk($sformatf("cleared_r%0d", i), readData1, 32'd0);
    end
    tick();
    chk("stay_idle", 32'(busy), 32'd0);

    // scan and wrap
    wr(5'd31, 32'h31);
    wr(5'd1, 32'h11);
    wr(5'd20, 32'h20);
    showAddress = 5'd30;
    tick();
    #1 chk("scan_start", 32'(display_addr), 32'd30);
    scan_en = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 3) chk("scan_hold", 32'(display_addr), 32'd30);
      if (c == 4) begin
        chk("scan_31", 32'(display_addr), 32'd31);
        chk("scan_d31", display, 32'h31);
      end
      if (c == 8) begin
        chk("scan_wrap0", 32'(display_addr), 32'd0);
        chk("scan_d0", display, 32'd0);
      end
      if (c == 12) begin
        chk("scan_1", 32'(display_addr), 32'd1);
        chk("scan_d1", display, 32'h11);
      end
    end

    // async reset mid-clear
    readReg1 = 5'd20;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_r20", readData1, 32'h20);
    chk("mid_daddr_nz", 32'(display_addr != 5'd0), 32'd1);
    rst = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_daddr", 32'(display_addr), 32'd0);
    chk("arst_r20", readData1, 32'd0);
    scan_en = 1'b0; showAddress = 5'd0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    #1 chk("idle_after", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
